// File: rtl/mem_fill_arbiter.sv
// Miss-service controller: arbitrates I/D cache misses onto the single memory read
// port, fetches one block as word reads and streams each returned word into the owner.
module mem_fill_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BLK_WORDS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_vld,
    output logic [DATA_W-1:0] fill_data,
    output logic [ADDR_W-1:0] fill_addr,
    output logic              i_data_we,
    output logic              i_meta_we,
    output logic              d_data_we,
    output logic              d_meta_we,
    output logic              i_stall,
    output logic              d_stall,
    output logic              busy
);
    // state | meaning
    // IDLE  | no fill in progress; a pending miss is granted here
    // FILL  | issue word reads, write each returned word into the owner's data array
    // META  | owner's metadata write strobe, after the last data write
    // WAIT  | one settle cycle so the serviced miss drops before re-arbitration

    localparam int CNT_W = $clog2(BLK_WORDS) + 1;
    localparam int OFF_W = $clog2(BLK_WORDS) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLK_WORDS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, FILL, META, WAIT} state_t;

    state_t            state;
    logic              owner_d;
    logic              last_grant_d;
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  rcv_cnt;
    logic              grant_d;
    logic [ADDR_W-1:0] req_base;
    logic              unused_addr_bits;

    function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    // Block base is aligned, so OR-ing in the word offset never carries.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] blk,
                                                    input logic [CNT_W-2:0]  idx);
        return blk | {{(ADDR_W-OFF_W){1'b0}}, idx, 1'b0};
    endfunction

    always_comb begin
        grant_d  = d_miss && (!i_miss || !last_grant_d);
        req_base = block_base(grant_d ? d_addr : i_addr);
    end

    assign unused_addr_bits = ^{i_addr[OFF_W-1:0], d_addr[OFF_W-1:0]};

    assign busy    = (state != IDLE);
    assign i_stall = i_miss || (busy && !owner_d);
    assign d_stall = d_miss || (busy && owner_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner_d      <= 1'b1;
            last_grant_d <= 1'b0;
            base         <= '0;
            issue_cnt    <= '0;
            rcv_cnt      <= '0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            fill_data    <= '0;
            fill_addr    <= '0;
            i_data_we    <= 1'b0;
            d_data_we    <= 1'b0;
            i_meta_we    <= 1'b0;
            d_meta_we    <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            i_data_we <= 1'b0;
            d_data_we <= 1'b0;
            i_meta_we <= 1'b0;
            d_meta_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_miss || d_miss) begin
                        owner_d      <= grant_d;
                        last_grant_d <= grant_d;
                        base         <= req_base;
                        // First read leaves with the grant; issue_cnt counts reads sent.
                        mem_rd_en    <= 1'b1;
                        mem_addr     <= req_base;
                        issue_cnt    <= CNT_ONE;
                        rcv_cnt      <= '0;
                        state        <= FILL;
                    end
                end
                FILL: begin
                    if (issue_cnt < CNT_FULL) begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= word_addr(base, issue_cnt[CNT_W-2:0]);
                        issue_cnt <= issue_cnt + CNT_ONE;
                    end
                    if (rcv_cnt == CNT_FULL) begin
                        // Last data strobe is on the outputs this cycle; meta follows it.
                        i_meta_we <= !owner_d;
                        d_meta_we <= owner_d;
                        state     <= META;
                    end else if (mem_vld) begin
                        fill_data <= mem_data;
                        fill_addr <= word_addr(base, rcv_cnt[CNT_W-2:0]);
                        i_data_we <= !owner_d;
                        d_data_we <= owner_d;
                        rcv_cnt   <= rcv_cnt + CNT_ONE;
                    end
                end
                META: state <= WAIT;
                WAIT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Bench for mem_fill_arbiter: time-based fill model plus an in-order memory with
// random latency, gaps and spurious returns; directed scenarios then random traffic.
module tb_mem_fill_arbiter;
    localparam int BW = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, mem_vld;
    logic [15:0] i_addr, d_addr, mem_data;
    logic        mem_rd_en;
    logic [15:0] mem_addr, fill_data, fill_addr;
    logic        i_data_we, i_meta_we, d_data_we, d_meta_we, i_stall, d_stall, busy;

    always #5 clk = ~clk;

    mem_fill_arbiter dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_addr(i_addr), .d_miss(d_miss), .d_addr(d_addr),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_data(mem_data), .mem_vld(mem_vld),
        .fill_data(fill_data), .fill_addr(fill_addr),
        .i_data_we(i_data_we), .i_meta_we(i_meta_we),
        .d_data_we(d_data_we), .d_meta_we(d_meta_we),
        .i_stall(i_stall), .d_stall(d_stall), .busy(busy)
    );

    typedef struct {logic [15:0] data; int rdy;} rd_t;
    rd_t mq[$];
    int  cyc = 0, lat_min = 1, lat_max = 1, gap_pct = 0, gap_at = -1, gap_left = 0, ret_cnt = 0;
    bit  spur = 0, armed = 0, auto_rel = 0, rel_i = 0, rel_d = 0;
    int  n_vec = 0, n_err = 0;

    // Model: a fill is a grant cycle plus a record of accepted returns; everything
    // else (reads, strobes, busy) follows from those times.
    bit          m_act = 0, m_own_d = 1, m_last_d = 0, m_we_d = 0;
    logic [15:0] m_base, m_we_addr, m_we_data;
    int          m_gcyc = 0, m_rcv = 0, m_end = 0, m_we_cyc = -1;

    int          g_own[$];
    logic [15:0] g_base[$];
    int          g_cyc[$];
    logic [15:0] obs_addr[$];
    int          obs_meta = 0, obs_meta_cyc = 0, obs_rd1 = -1;

    function automatic void chk1(string nm, logic a, logic e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %b, expected %b", nm, cyc, a, e);
        end
    endfunction

    function automatic void chk16(string nm, logic [15:0] a, logic [15:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", nm, cyc, a, e);
        end
    endfunction

    function automatic void chki(string nm, int a, int e);
        n_vec++;
        if (a != e) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, a, e);
        end
    endfunction

    task automatic cycle();
        bit          exp_busy, exp_rd, exp_dwe, exp_meta;
        logic [15:0] exp_addr;
        cyc++;
        mem_vld  = 1'b0;
        mem_data = 16'($urandom);
        if (spur) mem_vld = 1'b1;
        else if (mq.size() > 0 && mq[0].rdy <= cyc) begin
            if (ret_cnt == gap_at && gap_left > 0) gap_left--;
            else if (int'($urandom_range(99)) >= gap_pct) begin
                mem_vld  = 1'b1;
                mem_data = mq[0].data;
                void'(mq.pop_front());
                ret_cnt++;
            end
        end
        @(negedge clk);
        if (m_act && m_rcv == BW && cyc >= m_end) m_act = 0;
        exp_busy = m_act && cyc > m_gcyc && (m_rcv < BW || cyc < m_end);
        exp_rd   = m_act && cyc > m_gcyc && cyc <= m_gcyc + BW;
        exp_addr = m_base + 16'(2 * (cyc - m_gcyc - 1));
        exp_dwe  = (m_we_cyc == cyc);
        exp_meta = m_act && m_rcv == BW && cyc == m_end - 2;
        if (armed) begin
            chk1("busy", busy, exp_busy);
            chk1("mem_rd_en", mem_rd_en, exp_rd);
            if (exp_rd) chk16("mem_addr", mem_addr, exp_addr);
            chk1("i_data_we", i_data_we, exp_dwe && !m_we_d);
            chk1("d_data_we", d_data_we, exp_dwe && m_we_d);
            if (exp_dwe) begin
                chk16("fill_data", fill_data, m_we_data);
                chk16("fill_addr", fill_addr, m_we_addr);
            end
            chk1("i_meta_we", i_meta_we, exp_meta && !m_own_d);
            chk1("d_meta_we", d_meta_we, exp_meta && m_own_d);
            chk1("i_stall", i_stall, i_miss || (exp_busy && !m_own_d));
            chk1("d_stall", d_stall, d_miss || (exp_busy && m_own_d));
            if (i_data_we === 1'b1 || d_data_we === 1'b1) obs_addr.push_back(fill_addr);
            if (i_meta_we === 1'b1 || d_meta_we === 1'b1) begin
                obs_meta++;
                obs_meta_cyc = cyc;
            end
            if (mem_rd_en === 1'b1 && obs_rd1 < 0) obs_rd1 = cyc;
            if (auto_rel && i_meta_we === 1'b1) rel_i = 1;
            if (auto_rel && d_meta_we === 1'b1) rel_d = 1;
        end
        if (rst) begin
            m_act = 0; m_own_d = 1; m_last_d = 0; m_we_cyc = -1;
            armed = 1;
        end else begin
            if (m_act && cyc > m_gcyc && m_rcv < BW && mem_vld) begin
                m_we_cyc  = cyc + 1;
                m_we_d    = m_own_d;
                m_we_addr = m_base + 16'(2 * m_rcv);
                m_we_data = mem_data;
                m_rcv++;
                if (m_rcv == BW) m_end = cyc + 4;
            end
            if (!exp_busy && (i_miss || d_miss)) begin
                m_own_d  = d_miss && (!i_miss || !m_last_d);
                m_last_d = m_own_d;
                m_base   = (m_own_d ? d_addr : i_addr) & 16'hFFF0;
                m_gcyc   = cyc;
                m_rcv    = 0;
                m_act    = 1;
                g_own.push_back(int'(m_own_d));
                g_base.push_back(m_base);
                g_cyc.push_back(cyc);
            end
        end
        if (mem_rd_en === 1'b1)
            mq.push_back('{data: 16'($urandom), rdy: cyc + int'($urandom_range(lat_max, lat_min))});
        @(posedge clk);
        #1;
        if (rel_i) i_miss = 1'b0;
        if (rel_d) d_miss = 1'b0;
        rel_i = 0;
        rel_d = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        mq.delete();
        ret_cnt = 0;
    endtask

    task automatic clear_logs();
        obs_addr.delete(); g_own.delete(); g_base.delete(); g_cyc.delete();
        obs_meta = 0; obs_meta_cyc = 0; obs_rd1 = -1;
    endtask

    task automatic wait_idle(string nm, int max);
        int k = 0;
        while ((m_act || i_miss || d_miss) && k < max) begin
            cycle();
            k++;
        end
        if (m_act || i_miss || d_miss) begin
            n_vec++; n_err++;
            $display("FAIL timeout_%s @cyc %0d: still busy after %0d cycles", nm, cyc, max);
        end else cycle();
    endtask

    initial begin
        rst = 1'b1; i_miss = 0; d_miss = 0; i_addr = 0; d_addr = 0; mem_vld = 0; mem_data = 0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk16("rst_fill_data", fill_data, 16'h0000);
        chk16("rst_fill_addr", fill_addr, 16'h0000);
        chk1("rst_busy", busy, 1'b0);

        // single I miss, 1-cycle memory
        do_reset(); clear_logs();
        i_addr = 16'h1234; i_miss = 1; auto_rel = 1;
        wait_idle("single_i", 60);
        chki("t1_words", obs_addr.size(), 8);
        for (int k = 0; k < 8 && k < obs_addr.size(); k++)
            chk16("t1_fill_addr", obs_addr[k], 16'h1230 + 16'(2 * k));
        chki("t1_meta", obs_meta, 1);
        chki("t1_owner", (g_own.size() > 0) ? g_own[0] : -1, 0);
        if (g_cyc.size() > 0) begin
            chki("t1_first_rd_lat", obs_rd1 - g_cyc[0], 1);
            chki("t1_meta_lat", obs_meta_cyc - g_cyc[0], 11);
        end

        // simultaneous misses: D first, then I right after WAIT
        do_reset(); clear_logs();
        i_addr = 16'h0400; d_addr = 16'h8810; i_miss = 1; d_miss = 1; auto_rel = 1;
        wait_idle("tie", 100);
        chki("t2_grants", g_own.size(), 2);
        if (g_own.size() >= 2) begin
            chki("t2_first_owner", g_own[0], 1);
            chk16("t2_first_base", g_base[0], 16'h8810);
            chki("t2_second_owner", g_own[1], 0);
            chk16("t2_second_base", g_base[1], 16'h0400);
            chki("t2_regrant_gap", g_cyc[1] - g_cyc[0], 13);
        end
        chki("t2_words", obs_addr.size(), 16);
        if (obs_addr.size() == 16) begin
            chk16("t2_d_first", obs_addr[0], 16'h8810);
            chk16("t2_i_first", obs_addr[8], 16'h0400);
        end

        // both held across three fills: alternation D, I, D
        do_reset(); clear_logs();
        i_addr = 16'h3336; d_addr = 16'hC0DE; i_miss = 1; d_miss = 1; auto_rel = 0;
        for (int k = 0; k < 100 && g_own.size() < 3; k++) cycle();
        i_miss = 0; d_miss = 0;
        wait_idle("alt", 60);
        chki("t3_grants", g_own.size(), 3);
        if (g_own.size() >= 3) begin
            chki("t3_g0", g_own[0], 1);
            chki("t3_g1", g_own[1], 0);
            chki("t3_g2", g_own[2], 1);
        end

        // latency 3 with a 2-cycle return gap after word 4
        do_reset(); clear_logs();
        lat_min = 3; lat_max = 3; gap_at = 5; gap_left = 2;
        d_addr = 16'h5A5A; d_miss = 1; auto_rel = 1;
        wait_idle("gap", 80);
        chki("t4_words", obs_addr.size(), 8);
        for (int k = 0; k < 8 && k < obs_addr.size(); k++)
            chk16("t4_fill_addr", obs_addr[k], 16'h5A50 + 16'(2 * k));
        chki("t4_meta", obs_meta, 1);
        gap_at = -1;

        // reset mid-fill after five data strobes, trailing returns ignored
        do_reset(); clear_logs();
        lat_min = 8; lat_max = 8; auto_rel = 0;
        i_addr = 16'h2000; i_miss = 1;
        for (int k = 0; k < 60 && obs_addr.size() < 5; k++) cycle();
        chki("t5_reach5", obs_addr.size(), 5);
        rst = 1'b1; i_miss = 0;
        cycle();
        rst = 1'b0;
        chk1("t5_busy", busy, 1'b0);
        chk1("t5_rd_en", mem_rd_en, 1'b0);
        chk1("t5_i_data_we", i_data_we, 1'b0);
        chk1("t5_i_meta_we", i_meta_we, 1'b0);
        chk16("t5_fill_addr", fill_addr, 16'h0000);
        begin
            int n0;
            n0 = obs_addr.size();
            for (int k = 0; k < 6; k++) cycle();
            chki("t5_no_strobes", obs_addr.size(), n0);
            chki("t5_no_meta", obs_meta, 0);
        end

        // spurious returns while idle
        do_reset(); clear_logs();
        lat_min = 1; lat_max = 1;
        spur = 1;
        for (int k = 0; k < 5; k++) cycle();
        spur = 0;
        chki("t6_no_strobes", obs_addr.size(), 0);
        chki("t6_no_meta", obs_meta, 0);
        chk1("t6_idle", busy, 1'b0);

        // random traffic
        do_reset();
        lat_min = 1; lat_max = 4; gap_pct = 20; auto_rel = 0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(7) == 0) i_miss = !i_miss;
            if ($urandom_range(7) == 0) d_miss = !d_miss;
            if ($urandom_range(3) == 0) i_addr = 16'($urandom);
            if ($urandom_range(3) == 0) d_addr = 16'($urandom);
            spur = !m_act && mq.size() == 0 && $urandom_range(19) == 0;
            if ($urandom_range(499) == 0) do_reset();
            else cycle();
        end
        spur = 0; i_miss = 0; d_miss = 0;
        wait_idle("random", 80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
